// File: rtl/mapped_data_memory.sv
// Data memory with a self-clearing RAM and memory-mapped I/O registers.
// After reset the RAM is zeroed one word per cycle; accesses are ignored while BUSY.
module mapped_data_memory #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int IO_BASE = 256,
  parameter int N_OUT   = 3,
  parameter int N_IN    = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    STORE,
  input  logic                    LOAD,
  input  logic [ADDR_W-1:0]       ADDRESS,
  input  logic [DATA_W-1:0]       IO,
  output logic [DATA_W-1:0]       RDATA,
  output logic                    RVALID,
  output logic                    BUSY,
  output logic                    ERR,
  output logic [N_OUT*DATA_W-1:0] OUTPUTS,
  input  logic [N_IN*DATA_W-1:0]  INPUTS
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so IO_BASE+N_OUT+N_IN == 2^ADDR_W cannot wrap in the decode.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [N_OUT*DATA_W-1:0] out_q;
  logic [N_IN*DATA_W-1:0]  in_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    rvalid_q;
  logic                    err_q;

  logic [ADDR_W:0]         addr_x_s;
  logic                    is_ram_s;
  logic [N_OUT-1:0]        out_hit_s;
  logic [N_IN-1:0]         in_hit_s;
  logic                    mapped_s;
  logic [CNT_W-1:0]        ram_idx_s;
  logic [DATA_W-1:0]       rd_data_d;

  // Full-width address decode and read-data mux.
  always_comb begin
    addr_x_s  = {1'b0, ADDRESS};
    is_ram_s  = (addr_x_s < DEPTH_X);
    ram_idx_s = ADDRESS[CNT_W-1:0];
    for (int k = 0; k < N_OUT; k++) begin
      out_hit_s[k] = (addr_x_s == (ADDR_W+1)'(IO_BASE + k));
    end
    for (int j = 0; j < N_IN; j++) begin
      in_hit_s[j] = (addr_x_s == (ADDR_W+1)'(IO_BASE + N_OUT + j));
    end
    mapped_s  = is_ram_s | (|out_hit_s) | (|in_hit_s);
    rd_data_d = '0;
    if (is_ram_s) begin
      rd_data_d = mem_q[ram_idx_s];
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (out_hit_s[k]) rd_data_d = out_q[k*DATA_W +: DATA_W];
        else              rd_data_d = rd_data_d;
      end
      for (int j = 0; j < N_IN; j++) begin
        if (in_hit_s[j]) rd_data_d = in_q[j*DATA_W +: DATA_W];
        else             rd_data_d = rd_data_d;
      end
    end
  end

  // Control FSM, I/O registers, read pipeline and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      out_q    <= '0;
      in_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      in_q <= INPUTS;
      case (state_q)
        CLEAR: begin
          rvalid_q <= 1'b0;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) state_q <= IDLE;
          else                            state_q <= CLEAR;
        end
        IDLE: begin
          rvalid_q <= LOAD;
          if (LOAD) rdata_q <= rd_data_d;
          else      rdata_q <= rdata_q;
          for (int k = 0; k < N_OUT; k++) begin
            if (STORE && out_hit_s[k]) out_q[k*DATA_W +: DATA_W] <= IO;
          end
          if ((STORE && ((|in_hit_s) || !mapped_s)) || (LOAD && !mapped_s)) err_q <= 1'b1;
          else                                                              err_q <= err_q;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // RAM array: zeroed by the clear sweep, otherwise written by stores.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == CLEAR)          mem_q[cnt_q]     <= '0;
      else if (STORE && is_ram_s)    mem_q[ram_idx_s] <= IO;
    end
  end

  assign BUSY    = (state_q == CLEAR);
  assign RDATA   = rdata_q;
  assign RVALID  = rvalid_q;
  assign ERR     = err_q;
  assign OUTPUTS = out_q;

endmodule

// File: tb/tb_mapped_data_memory.sv
// Directed, table-driven bench for mapped_data_memory (default parameters).
module tb_mapped_data_memory;

  logic        clk = 1'b0;
  logic        reset, store, load, rvalid, busy, err;
  logic [15:0] address;
  logic [7:0]  io, rdata, inputs;
  logic [23:0] outputs;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        st;
    logic        ld;
    logic [15:0] addr;
    logic [7:0]  io;
    logic        rv;
    logic [7:0]  rd;
    logic        err;
    logic [23:0] outs;
  } vec_t;

  vec_t vt [27];

  mapped_data_memory dut (
    .CLK(clk), .RESET(reset), .STORE(store), .LOAD(load), .ADDRESS(address),
    .IO(io), .RDATA(rdata), .RVALID(rvalid), .BUSY(busy), .ERR(err),
    .OUTPUTS(outputs), .INPUTS(inputs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one access for one cycle; outputs are sampled 1ns after the edge.
  task automatic op(input logic st, input logic ld, input logic [15:0] a, input logic [7:0] d);
    store = st; load = ld; address = a; io = d;
    @(posedge clk); #1;
    store = 1'b0; load = 1'b0;
  endtask

  // Count cycles with BUSY=1 from now, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    vt[0]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0, 24'h000000};
    vt[1]  = '{1'b0, 1'b1, 16'h00FF, 8'h00, 1'b1, 8'h00, 1'b0, 24'h000000};
    vt[2]  = '{1'b1, 1'b0, 16'h0010, 8'hA5, 1'b0, 8'h00, 1'b0, 24'h000000};
    vt[3]  = '{1'b0, 1'b1, 16'h0010, 8'h00, 1'b1, 8'hA5, 1'b0, 24'h000000};
    vt[4]  = '{1'b1, 1'b1, 16'h0010, 8'h3C, 1'b1, 8'hA5, 1'b0, 24'h000000};
    vt[5]  = '{1'b0, 1'b1, 16'h0010, 8'h00, 1'b1, 8'h3C, 1'b0, 24'h000000};
    vt[6]  = '{1'b1, 1'b0, 16'h0100, 8'h11, 1'b0, 8'h3C, 1'b0, 24'h000011};
    vt[7]  = '{1'b1, 1'b0, 16'h0101, 8'h22, 1'b0, 8'h3C, 1'b0, 24'h002211};
    vt[8]  = '{1'b1, 1'b0, 16'h0102, 8'h33, 1'b0, 8'h3C, 1'b0, 24'h332211};
    vt[9]  = '{1'b0, 1'b1, 16'h0101, 8'h00, 1'b1, 8'h22, 1'b0, 24'h332211};
    vt[10] = '{1'b0, 1'b1, 16'h0103, 8'h00, 1'b1, 8'h7E, 1'b0, 24'h332211};
    vt[11] = '{1'b1, 1'b0, 16'h0103, 8'h55, 1'b0, 8'h7E, 1'b1, 24'h332211};
    vt[12] = '{1'b0, 1'b1, 16'h0103, 8'h00, 1'b1, 8'h7E, 1'b1, 24'h332211};
    vt[13] = '{1'b0, 1'b1, 16'h1000, 8'h00, 1'b1, 8'h00, 1'b1, 24'h332211};
    vt[14] = '{1'b0, 1'b1, 16'h8010, 8'h00, 1'b1, 8'h00, 1'b1, 24'h332211};
    vt[15] = '{1'b0, 1'b1, 16'h0104, 8'h00, 1'b1, 8'h00, 1'b1, 24'h332211};
    vt[16] = '{1'b1, 1'b0, 16'h0001, 8'h01, 1'b0, 8'h00, 1'b1, 24'h332211};
    vt[17] = '{1'b1, 1'b0, 16'h0002, 8'h02, 1'b0, 8'h00, 1'b1, 24'h332211};
    vt[18] = '{1'b1, 1'b0, 16'h0003, 8'h03, 1'b0, 8'h00, 1'b1, 24'h332211};
    vt[19] = '{1'b0, 1'b1, 16'h0001, 8'h00, 1'b1, 8'h01, 1'b1, 24'h332211};
    vt[20] = '{1'b0, 1'b1, 16'h0002, 8'h00, 1'b1, 8'h02, 1'b1, 24'h332211};
    vt[21] = '{1'b0, 1'b1, 16'h0003, 8'h00, 1'b1, 8'h03, 1'b1, 24'h332211};
    vt[22] = '{1'b0, 1'b1, 16'h0100, 8'h00, 1'b1, 8'h11, 1'b1, 24'h332211};
    vt[23] = '{1'b1, 1'b0, 16'h0005, 8'hFF, 1'b0, 8'h11, 1'b1, 24'h332211};
    vt[24] = '{1'b0, 1'b1, 16'h0005, 8'h00, 1'b1, 8'hFF, 1'b1, 24'h332211};
    vt[25] = '{1'b1, 1'b0, 16'h8011, 8'h77, 1'b0, 8'hFF, 1'b1, 24'h332211};
    vt[26] = '{1'b0, 1'b1, 16'h0011, 8'h00, 1'b1, 8'h00, 1'b1, 24'h332211};

    store = 1'b0; load = 1'b0; address = 16'h0000; io = 8'h00; inputs = 8'h7E;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_outputs", 32'(outputs), 32'd0);
    reset = 1'b0;
    count_busy(n);
    check("busy_cycles", 32'(n), 32'd256);

    for (int i = 0; i < 27; i++) begin
      op(vt[i].st, vt[i].ld, vt[i].addr, vt[i].io);
      check($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vt[i].rv));
      check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vt[i].rd));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].err));
      check($sformatf("v%0d_outputs", i), 32'(outputs), 32'(vt[i].outs));
    end

    // Reset with a same-cycle store/load: reset must win.
    store = 1'b1; load = 1'b1; address = 16'h0100; io = 8'h99;
    pulse_reset();
    check("rp_outputs", 32'(outputs), 32'd0);
    check("rp_rvalid", 32'(rvalid), 32'd0);
    check("rp_rdata", 32'(rdata), 32'd0);
    check("rp_err", 32'(err), 32'd0);
    check("rp_busy", 32'(busy), 32'd1);

    // Accesses during the clear sweep must be ignored.
    bad = 0;
    inputs = 8'h5A;
    store = 1'b1; load = 1'b1;
    for (int i = 0; i < 100; i++) begin
      address = (i < 50) ? 16'h1000 : 16'h0100;
      io = 8'h99;
      @(posedge clk); #1;
      if (rvalid !== 1'b0 || err !== 1'b0 || outputs !== 24'h0 || busy !== 1'b1) bad++;
    end
    store = 1'b0; load = 1'b0;
    check("busy_ignore", 32'(bad), 32'd0);

    // Reset mid-clear restarts the full sweep.
    pulse_reset();
    count_busy(n);
    check("reclear_cycles", 32'(n), 32'd256);
    check("reclear_err", 32'(err), 32'd0);
    check("reclear_outputs", 32'(outputs), 32'd0);

    op(1'b0, 1'b1, 16'h0005, 8'h00);
    check("rc_ld5_rvalid", 32'(rvalid), 32'd1);
    check("rc_ld5_rdata", 32'(rdata), 32'd0);
    op(1'b0, 1'b1, 16'h0010, 8'h00);
    check("rc_ld10_rdata", 32'(rdata), 32'd0);
    op(1'b0, 1'b1, 16'h0102, 8'h00);
    check("rc_ldout_rdata", 32'(rdata), 32'd0);
    op(1'b0, 1'b1, 16'h0103, 8'h00);
    check("rc_ldin_rdata", 32'(rdata), 32'h5A);
    @(posedge clk); #1;
    check("rv_single_pulse", 32'(rvalid), 32'd0);
    check("rdata_hold", 32'(rdata), 32'h5A);
    check("final_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mapped_data_memory.md
MAPPED_DATA_MEMORY -- requirements
Module: mapped_data_memory

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 8, data width
- ADDR_W, 16, address width
- DEPTH, 256, RAM words, at addresses 0..DEPTH-1
- IO_BASE, 256, first I/O-mapped address
- N_OUT, 3, output channels
- N_IN, 1, input channels

REQ-002 Parameter legality SHALL be: IO_BASE >= DEPTH; IO_BASE+N_OUT+N_IN <= 2^ADDR_W; N_OUT >= 1; N_IN >= 1.

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK, in, 1, sole clock, rising edge
- RESET, in, 1, synchronous, active-high
- STORE, in, 1, write request
- LOAD, in, 1, read request
- ADDRESS, in, ADDR_W, access address
- IO, in, DATA_W, write data
- RDATA, out, DATA_W, read data
- RVALID, out, 1, read-data-valid pulse
- BUSY, out, 1, clear in progress
- ERR, out, 1, sticky illegal-access flag
- OUTPUTS, out, N_OUT*DATA_W, channel k at bits [k*DATA_W +: DATA_W]
- INPUTS, in, N_IN*DATA_W, channel k at bits [k*DATA_W +: DATA_W]

REQ-004 The block SHALL use one clock (CLK) and a synchronous, active-high reset (RESET).

Function
REQ-005 Address map: RAM at 0..DEPTH-1; output register k (read/write) at IO_BASE+k; input register j (read-only) at IO_BASE+N_OUT+j; every other address is unmapped.

REQ-006 Address decode SHALL compare the full ADDR_W bits, with no aliasing and no wrap-around.

REQ-007 The FSM SHALL have two states, CLEAR and IDLE; BUSY=1 exactly when the state is CLEAR.

REQ-008 In CLEAR, each cycle SHALL write 0 to RAM[cnt] and increment cnt; after writing cnt=DEPTH-1, the FSM SHALL enter IDLE.

REQ-009 The first clock edge with RESET=0 SHALL clear RAM[0]; BUSY SHALL read 0 starting DEPTH cycles after the last reset edge.

REQ-010 While BUSY=1, STORE and LOAD SHALL be ignored: no write, RVALID=0, and ERR unchanged.

REQ-011 In IDLE, a STORE to RAM or to an output address SHALL write IO at that edge; an output-register value SHALL appear on OUTPUTS in the next cycle.

REQ-012 A STORE to an input or unmapped address SHALL write nothing and SHALL set ERR.

REQ-013 A LOAD in IDLE SHALL produce, one cycle later, RVALID=1 for exactly one cycle, with RDATA equal to the addressed RAM word, output register, or sampled input register.

REQ-014 A LOAD to an unmapped address SHALL return RDATA=0 with RVALID=1 and SHALL set ERR.

REQ-015 RDATA SHALL hold its last value when no read completes.

REQ-016 LOADs on consecutive cycles SHALL give back-to-back RVALID pulses, one per request, in order.

REQ-017 STORE and LOAD to the same address in the same cycle SHALL return the old data (read-before-write); the new data SHALL be visible to the following LOAD.

REQ-018 INPUTS SHALL be registered every cycle, including during CLEAR; a LOAD SHALL return the value sampled at the edge before the LOAD edge.

REQ-019 ERR SHALL stay at 1 until RESET.

Reset
REQ-020 On a RESET edge the block SHALL set: state=CLEAR, cnt=0, OUTPUTS=0, input registers=0, RDATA=0, RVALID=0, ERR=0, BUSY=1.

REQ-021 RESET asserted mid-CLEAR SHALL restart the clear at cnt=0.

REQ-022 RESET asserted in IDLE SHALL re-clear the whole RAM.

REQ-023 RESET SHALL take priority over STORE and LOAD in the same cycle.

Verification
REQ-024 The bench SHALL cover these directed scenarios (defaults):
- Reset 1 cycle, then release; poll BUSY -> BUSY=1 for exactly 256 cycles, then 0; LOAD addr 0 and addr 255 -> RDATA=0x00, RVALID=1 each.
- STORE 0xA5@0x0010, then LOAD 0x0010 -> RVALID one cycle later, RDATA=0xA5; same-cycle STORE 0x3C and LOAD @0x0010 -> RDATA=0xA5; next LOAD -> 0x3C.
- STORE 0x11@256, 0x22@257, 0x33@258 -> OUTPUTS=0x332211 one cycle after the last store; LOAD 257 -> 0x22.
- INPUTS=0x7E, LOAD 259 -> 0x7E; STORE 0x55@259 -> ERR=1, LOAD 259 still 0x7E; LOAD 0x1000 -> RDATA=0x00, RVALID=1, ERR remains 1.
- STORE 0xFF@5, then reset held 1 cycle, then wait 100 cycles; reset again, wait until BUSY=0 -> LOAD 5 returns 0x00; OUTPUTS=0, ERR=0; LOAD/STORE during BUSY -> no RVALID, ERR stays 0.
- LOAD on 4 consecutive cycles to 1,2,3,256 -> 4 consecutive RVALID pulses with data in request order.
